// File: rtl/aes_key_pkg.sv
// Shared state encoding, memory map and constants for the AES-128 key schedule sequencer.
package aes_key_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SUB,
        RCON,
        RCON_WAIT,
        SB_WAIT,
        COMBINE,
        DONE
    } ks_state_t;

    localparam logic [3:0]  NUM_ROUNDS = 4'd10;
    localparam logic [11:0] SBOX_BASE  = 12'd0;
    localparam logic [11:0] RCON_BASE  = 12'd256;

    localparam logic [7:0] RCON_TABLE [0:9] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
        8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    function automatic logic [31:0] rot_word(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

endpackage

// File: rtl/key_schedule_ctrl_if.sv
// Unified-memory read port shared with the datapath: one lookup per granted cycle,
// read data returned exactly one cycle after acceptance.
interface key_schedule_ctrl_if;
    logic         mem_req;
    logic [11:0]  mem_addr;
    logic         mem_gnt;
    logic [127:0] mem_rdata;

    modport master (output mem_req, mem_addr, input mem_gnt, mem_rdata);
    modport slave  (input mem_req, mem_addr, output mem_gnt, mem_rdata);
endinterface

// File: rtl/key_word_mix.sv
// Combinational AES-128 round-key step: previous round key, SubWord(RotWord(w3)) and
// Rcon in, next round key out (zero latency, no flow control).
module key_word_mix (
    input  logic [127:0] i_prev_rk,
    input  logic [31:0]  i_sub_word,
    input  logic [7:0]   i_rcon,
    output logic [127:0] o_next_rk
);
    logic [31:0] w_temp;
    logic [31:0] w_w4;
    logic [31:0] w_w5;
    logic [31:0] w_w6;
    logic [31:0] w_w7;

    assign w_temp    = i_sub_word ^ {i_rcon, 24'h0};
    assign w_w4      = i_prev_rk[127:96] ^ w_temp;
    assign w_w5      = i_prev_rk[95:64]  ^ w_w4;
    assign w_w6      = i_prev_rk[63:32]  ^ w_w5;
    assign w_w7      = i_prev_rk[31:0]   ^ w_w6;
    assign o_next_rk = {w_w4, w_w5, w_w6, w_w7};
endmodule

// File: rtl/key_schedule_ctrl.sv
// Iterative AES-128 key expansion into an 11-entry register file; 7 cycles/round with a free
// memory port (6 with KEY_SCHED_RCON_ROM_EN), stalls one cycle per ungranted request.
module key_schedule_ctrl
    import aes_key_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic [127:0]               key_in,
    output logic                       busy,
    output logic                       done,
    output logic                       keys_valid,
    key_schedule_ctrl_if.master        mem,
    input  logic [3:0]                 rk_idx,
    output logic [127:0]               rk_data
);
    ks_state_t    r_state;
    ks_state_t    w_next_state;
    logic [3:0]   r_round;
    logic [1:0]   r_byte_cnt;
    logic         r_pend;
    logic [1:0]   r_pend_idx;
    logic [31:0]  r_sub;
    logic         r_keys_valid;
    logic [127:0] r_rk [0:NUM_ROUNDS];

    logic [127:0] w_prev_rk;
    logic [31:0]  w_rot;
    logic [7:0]   w_sbox_idx;
    logic [7:0]   w_rcon;
    logic [127:0] w_next_rk;
    logic         w_unused_rdata;

    assign w_prev_rk      = r_rk[r_round - 4'd1];
    assign w_rot          = rot_word(w_prev_rk[31:0]);
    assign w_unused_rdata = ^mem.mem_rdata[127:8];

    always_comb begin
        w_sbox_idx = w_rot[31:24];
        case (r_byte_cnt)
            2'd1:    w_sbox_idx = w_rot[23:16];
            2'd2:    w_sbox_idx = w_rot[15:8];
            2'd3:    w_sbox_idx = w_rot[7:0];
            default: w_sbox_idx = w_rot[31:24];
        endcase
    end

`ifdef KEY_SCHED_RCON_ROM_EN
    assign w_rcon = RCON_TABLE[r_round - 4'd1];
`else
    logic [7:0] r_rcon;
    assign w_rcon = r_rcon;
`endif

    key_word_mix u_mix (
        .i_prev_rk  (w_prev_rk),
        .i_sub_word (r_sub),
        .i_rcon     (w_rcon),
        .o_next_rk  (w_next_rk)
    );

    always_comb begin
        w_next_state = r_state;
        mem.mem_req  = 1'b0;
        mem.mem_addr = '0;
        case (r_state)
            IDLE: begin
                if (start) w_next_state = SUB;
            end
            SUB: begin
                mem.mem_req  = 1'b1;
                mem.mem_addr = SBOX_BASE + {4'h0, w_sbox_idx};
                if (mem.mem_gnt && (r_byte_cnt == 2'd3)) begin
`ifdef KEY_SCHED_RCON_ROM_EN
                    w_next_state = SB_WAIT;
`else
                    w_next_state = RCON;
`endif
                end
            end
`ifdef KEY_SCHED_RCON_ROM_EN
            SB_WAIT: w_next_state = COMBINE;
`else
            RCON: begin
                mem.mem_req  = 1'b1;
                mem.mem_addr = RCON_BASE + {8'h0, (r_round - 4'd1)};
                if (mem.mem_gnt) w_next_state = RCON_WAIT;
            end
            RCON_WAIT: w_next_state = COMBINE;
`endif
            COMBINE: w_next_state = (r_round == NUM_ROUNDS) ? DONE : SUB;
            DONE:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next_state;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_round      <= 4'd1;
            r_byte_cnt   <= 2'd0;
            r_pend       <= 1'b0;
            r_pend_idx   <= 2'd0;
            r_sub        <= '0;
            r_keys_valid <= 1'b0;
`ifndef KEY_SCHED_RCON_ROM_EN
            r_rcon       <= '0;
`endif
            for (int i = 0; i <= int'(NUM_ROUNDS); i++) r_rk[i] <= '0;
        end else begin
            // S-box data lands one cycle after its grant, independent of where the FSM went.
            r_pend     <= (r_state == SUB) && mem.mem_gnt;
            r_pend_idx <= r_byte_cnt;
            if (r_pend) begin
                case (r_pend_idx)
                    2'd0:    r_sub[31:24] <= mem.mem_rdata[7:0];
                    2'd1:    r_sub[23:16] <= mem.mem_rdata[7:0];
                    2'd2:    r_sub[15:8]  <= mem.mem_rdata[7:0];
                    default: r_sub[7:0]   <= mem.mem_rdata[7:0];
                endcase
            end
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_rk[0]      <= key_in;
                        r_round      <= 4'd1;
                        r_byte_cnt   <= 2'd0;
                        r_keys_valid <= 1'b0;
                    end
                end
                SUB: begin
                    if (mem.mem_gnt) r_byte_cnt <= r_byte_cnt + 2'd1;
                end
`ifndef KEY_SCHED_RCON_ROM_EN
                RCON_WAIT: r_rcon <= mem.mem_rdata[7:0];
`endif
                COMBINE: begin
                    r_rk[r_round] <= w_next_rk;
                    r_byte_cnt    <= 2'd0;
                    if (r_round != NUM_ROUNDS) r_round <= r_round + 4'd1;
                end
                DONE:    r_keys_valid <= 1'b1;
                default: ;
            endcase
        end
    end

    assign busy       = (r_state != IDLE) && (r_state != DONE);
    assign done       = (r_state == DONE);
    assign keys_valid = r_keys_valid;

    always_comb begin
        rk_data = '0;
        if (rk_idx <= NUM_ROUNDS) rk_data = r_rk[rk_idx];
    end
endmodule

// File: tb/tb_key_schedule_ctrl.sv
// Directed bench for key_schedule_ctrl with a unified-memory model (S-box + Rcon) behind the port.
module tb_key_schedule_ctrl;
    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [127:0] key_in;
    logic         busy;
    logic         done;
    logic         keys_valid;
    logic [3:0]   rk_idx;
    logic [127:0] rk_data;

    key_schedule_ctrl_if mif();

    key_schedule_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .key_in     (key_in),
        .busy       (busy),
        .done       (done),
        .keys_valid (keys_valid),
        .mem        (mif.master),
        .rk_idx     (rk_idx),
        .rk_data    (rk_data)
    );

    always #5 clk = ~clk;

    localparam logic [127:0] FIPS_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] FIPS_RK1  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] FIPS_RK2  = 128'hf2c295f27a96b9435935807a7359f67f;
    localparam logic [127:0] FIPS_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] ZERO_RK1  = 128'h62636363626363636263636362636363;
    localparam logic [127:0] ZERO_RK10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

`ifdef KEY_SCHED_RCON_ROM_EN
    localparam int          EXP_DONE     = 61;
    localparam int          EXP_ACC      = 40;
    localparam int          EXP_RCON_ACC = 0;
    localparam logic [11:0] EXP_ADDR4    = 12'h06c;
`else
    localparam int          EXP_DONE     = 71;
    localparam int          EXP_ACC      = 50;
    localparam int          EXP_RCON_ACC = 10;
    localparam logic [11:0] EXP_ADDR4    = 12'h100;
`endif

    logic [127:0] sbox_rows [16] = '{
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };
    logic [7:0] rcon_tab [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                  8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

    logic [11:0] acc_q [$];
    int checks = 0;
    int errors = 0;

    function automatic logic [7:0] mem_byte(input logic [11:0] a);
        logic [127:0] row;
        if (a < 12'd256) begin
            row = sbox_rows[a[7:4]];
            return row[8 * (15 - int'(a[3:0])) +: 8];
        end
        if (a < 12'd266) return rcon_tab[int'(a) - 256];
        return 8'h00;
    endfunction

    // Accepted reads return data next cycle; every other cycle returns junk.
    always @(posedge clk) begin
        if (mif.mem_req && mif.mem_gnt) begin
            mif.mem_rdata <= {120'h0, mem_byte(mif.mem_addr)};
            acc_q.push_back(mif.mem_addr);
        end else begin
            mif.mem_rdata <= {$urandom(), $urandom(), $urandom(), $urandom()};
        end
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic read_rk(input int i, output logic [127:0] d);
        rk_idx = 4'(i);
        #1;
        d = rk_data;
    endtask

    task automatic run_sched(input logic [127:0] key, input bit rnd, input int pulse_cyc,
                             output int dcyc, output int stalls, output int addr_bad);
        logic [11:0] held;
        bit          hold;
        dcyc = 0; stalls = 0; addr_bad = 0; hold = 1'b0; held = '0;
        @(posedge clk); #1;
        mif.mem_gnt = 1'b1;
        rk_idx      = 4'd0;
        key_in      = key;
        start       = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("busy_cycle1", busy, 1'b1);
        check("keys_valid_cycle1", keys_valid, 1'b0);
        check("rk0_cycle1", rk_data, key);
        for (int n = 1; n < 400; n++) begin
            if (done) begin
                dcyc = n;
                break;
            end
            if (n == pulse_cyc) begin
                start  = 1'b1;
                key_in = ~key;
            end else begin
                start = 1'b0;
            end
            if (hold && (!mif.mem_req || mif.mem_addr !== held)) addr_bad++;
            mif.mem_gnt = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            hold = mif.mem_req && !mif.mem_gnt;
            held = mif.mem_addr;
            if (hold) stalls++;
            @(posedge clk); #1;
        end
        start       = 1'b0;
        mif.mem_gnt = 1'b1;
        @(posedge clk); #1;
        check("done_one_cycle", done, 1'b0);
        check("keys_valid_after_done", keys_valid, 1'b1);
        check("busy_after_done", busy, 1'b0);
    endtask

    initial begin
        logic [127:0] d;
        int dcyc, stalls, abad, n_rc;

        rst_n = 1'b0; start = 1'b0; key_in = '0; rk_idx = 4'd0; mif.mem_gnt = 1'b1;
        #2;
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_keys_valid", keys_valid, 1'b0);
        check("rst_mem_req", mif.mem_req, 1'b0);
        check("rst_mem_addr", mif.mem_addr, 12'h000);
        read_rk(0, d);  check("rst_rk0", d, 128'h0);
        read_rk(10, d); check("rst_rk10", d, 128'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // FIPS key, permanent grant, with address trace
        acc_q.delete();
        run_sched(FIPS_KEY, 1'b0, 0, dcyc, stalls, abad);
        check("t1_done_cycle", dcyc, EXP_DONE);
        read_rk(0, d);  check("t1_rk0", d, FIPS_KEY);
        read_rk(1, d);  check("t1_rk1", d, FIPS_RK1);
        read_rk(2, d);  check("t1_rk2", d, FIPS_RK2);
        read_rk(10, d); check("t1_rk10", d, FIPS_RK10);
        check("t1_access_count", acc_q.size(), EXP_ACC);
        check("t1_addr0", acc_q[0], 12'h0cf);
        check("t1_addr1", acc_q[1], 12'h04f);
        check("t1_addr2", acc_q[2], 12'h03c);
        check("t1_addr3", acc_q[3], 12'h009);
        check("t1_addr4", acc_q[4], EXP_ADDR4);

        // Same key, ~50% grant
        acc_q.delete();
        run_sched(FIPS_KEY, 1'b1, 0, dcyc, stalls, abad);
        check("t2_done_cycle", dcyc, EXP_DONE + stalls);
        check("t2_saw_stalls", stalls > 0, 1'b1);
        check("t2_addr_stable", abad, 0);
        read_rk(1, d);  check("t2_rk1", d, FIPS_RK1);
        read_rk(10, d); check("t2_rk10", d, FIPS_RK10);
        n_rc = 0;
        foreach (acc_q[i]) if (acc_q[i] >= 12'd256) n_rc++;
        check("t2_rcon_accesses", n_rc, EXP_RCON_ACC);

        // Zero key; a start pulse with another key mid-run must be ignored
        run_sched(128'h0, 1'b0, 20, dcyc, stalls, abad);
        check("t3_done_cycle", dcyc, EXP_DONE);
        read_rk(0, d);  check("t3_rk0", d, 128'h0);
        read_rk(1, d);  check("t3_rk1", d, ZERO_RK1);
        read_rk(10, d); check("t3_rk10", d, ZERO_RK10);

        // Asynchronous reset in cycle 30, then a clean run
        @(posedge clk); #1;
        key_in = FIPS_KEY;
        start  = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (29) @(posedge clk);
        #1;
        check("t4_busy_cycle30", busy, 1'b1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("t4_rst_mem_req", mif.mem_req, 1'b0);
        check("t4_rst_busy", busy, 1'b0);
        check("t4_rst_keys_valid", keys_valid, 1'b0);
        for (int i = 0; i <= 10; i++) begin
            read_rk(i, d);
            check("t4_rk_cleared", d, 128'h0);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        run_sched(FIPS_KEY, 1'b0, 0, dcyc, stalls, abad);
        check("t4_done_cycle", dcyc, EXP_DONE);
        read_rk(1, d);  check("t4_rk1", d, FIPS_RK1);
        read_rk(10, d); check("t4_rk10", d, FIPS_RK10);

        // Out-of-range indices read zero
        for (int i = 11; i <= 15; i++) begin
            read_rk(i, d);
            check("t5_rk_out_of_range", d, 128'h0);
        end
        read_rk(0, d); check("t5_rk0", d, FIPS_KEY);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
